// File: rtl/ibuffer.sv
// ---------------------------------------------------------------------------
// ibuffer -- instruction buffer between fetch and decode
//
// In-order FIFO of (instruction, PC) pairs. Fetch pushes with a valid/ready
// handshake, decode pops the head with a valid/ready handshake, and a backend
// redirect flushes every entry at the next clock edge.
//
// Parameters
//   DEPTH               number of entries (power of 2, minimum 2)
//
// Ports
//   clock               sole clock, all state updates on the rising edge
//   reset_n             asynchronous active-low reset (pointers and count)
//   fetch_instr_valid   fetch offers an instruction this cycle
//   fetch_instr[31:0]   instruction word from fetch
//   fetch_pc[63:0]      PC of fetch_instr
//   fetch_instr_ready   buffer accepts the offer this cycle
//   ibuf_instr_valid    head entry valid toward decode
//   ibuf_instr[31:0]    head instruction word
//   ibuf_pc[63:0]       head PC
//   ibuf_instr_ready    decode consumes the head this cycle
//   redirect_valid      backend redirect; flush all entries
//   ibuf_count          current occupancy (0..DEPTH)
//
// Build option
//   IBUFFER_BYPASS_EN   when defined, an offer that arrives while the buffer
//                       is empty is presented on ibuf_* in the same cycle; if
//                       decode takes it, it is never written into storage.
//                       When undefined there is no combinational path from
//                       fetch_* to ibuf_* and a pushed entry reaches the
//                       head one cycle later.
// ---------------------------------------------------------------------------
module ibuffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fetch_instr_valid,
    input  logic [31:0]              fetch_instr,
    input  logic [63:0]              fetch_pc,
    output logic                     fetch_instr_ready,
    output logic                     ibuf_instr_valid,
    output logic [31:0]              ibuf_instr,
    output logic [63:0]              ibuf_pc,
    input  logic                     ibuf_instr_ready,
    input  logic                     redirect_valid,
    output logic [$clog2(DEPTH):0]   ibuf_count
);

    localparam int AW = $clog2(DEPTH);

    // Occupancy needs one more bit than the pointers so that "full" (DEPTH)
    // and "empty" (0) are distinct while both pointers are equal.
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Storage: deliberately not reset, contents are don't-care until written.
    logic [31:0]   r_mem_instr [DEPTH];
    logic [63:0]   r_mem_pc    [DEPTH];

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Full/empty are decided from the occupancy counter only; pointer
    // equality is ambiguous once the pointers wrap.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == CNT_ZERO);

    // A full buffer refuses an offer even when decode frees a slot in the
    // same cycle, which keeps ready independent of ibuf_instr_ready.
    assign fetch_instr_ready = !w_full && !redirect_valid;

    // Only stored entries are popped from the array; a bypassed instruction
    // never occupies a slot, so it never moves the read pointer.
    assign w_pop = ibuf_instr_ready && !w_empty && !redirect_valid;

`ifdef IBUFFER_BYPASS_EN
    logic w_bypass;

    // Bypass is only taken while nothing is stored (ordering is preserved)
    // and never during a redirect (the offer belongs to the flushed path).
    assign w_bypass = w_empty && fetch_instr_valid && !redirect_valid;

    assign ibuf_instr_valid = (!w_empty && !redirect_valid) || w_bypass;
    assign ibuf_instr       = w_bypass ? fetch_instr : r_mem_instr[r_rd_ptr];
    assign ibuf_pc          = w_bypass ? fetch_pc    : r_mem_pc[r_rd_ptr];

    // An instruction consumed straight off the bypass is not written.
    assign w_push = fetch_instr_valid && fetch_instr_ready
                    && !(w_bypass && ibuf_instr_ready);
`else
    // Head outputs come from storage only: a pushed entry is visible one
    // cycle after it is accepted.
    assign ibuf_instr_valid = !w_empty && !redirect_valid;
    assign ibuf_instr       = r_mem_instr[r_rd_ptr];
    assign ibuf_pc          = r_mem_pc[r_rd_ptr];

    assign w_push = fetch_instr_valid && fetch_instr_ready;
`endif

    assign ibuf_count = r_count;

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            2'b11:   w_count_next = r_count;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer and occupancy state; redirect flushes ahead of any push/pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else if (redirect_valid) begin
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= fetch_instr;
            r_mem_pc[r_wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_ibuffer.sv
// Directed testbench for ibuffer (DEPTH = 8). Inputs are driven on the
// falling edge and outputs sampled 1 time unit later, well away from the
// rising edge where state changes.
module tb_ibuffer;

    logic        clock;
    logic        reset_n;
    logic        fetch_instr_valid;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        fetch_instr_ready;
    logic        ibuf_instr_valid;
    logic [31:0] ibuf_instr;
    logic [63:0] ibuf_pc;
    logic        ibuf_instr_ready;
    logic        redirect_valid;
    logic [3:0]  ibuf_count;

    int checks;
    int failures;

    ibuffer #(.DEPTH(8)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .fetch_instr_valid (fetch_instr_valid),
        .fetch_instr       (fetch_instr),
        .fetch_pc          (fetch_pc),
        .fetch_instr_ready (fetch_instr_ready),
        .ibuf_instr_valid  (ibuf_instr_valid),
        .ibuf_instr        (ibuf_instr),
        .ibuf_pc           (ibuf_pc),
        .ibuf_instr_ready  (ibuf_instr_ready),
        .redirect_valid    (redirect_valid),
        .ibuf_count        (ibuf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction word tied to its PC so instr and pc can be checked together.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Drive one cycle of inputs at the falling edge, settle for 1 unit.
    task automatic drive(input logic fv, input logic [63:0] pc, input logic rdy, input logic redir);
        @(negedge clock);
        fetch_instr_valid = fv;
        fetch_pc          = pc;
        fetch_instr       = instr_of(pc);
        ibuf_instr_ready  = rdy;
        redirect_valid    = redir;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fetch_instr_valid = 1'b0; fetch_pc = 64'd0; fetch_instr = 32'd0;
        ibuf_instr_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        checks++; if (ibuf_instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ibuf_instr_valid); end
        checks++; if (ibuf_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ibuf_count); end
        checks++; if (fetch_instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", fetch_instr_ready); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Fill with decode stalled; head must stay on the first entry.
    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
            checks++; if (fetch_instr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, fetch_instr_ready); end
            if (i > 0) begin
                checks++; if (ibuf_pc !== 64'h8000_0000 || ibuf_instr_valid !== 1'b1) begin failures++; $display("FAIL fill_head_hold[%0d] got=%h/%b exp=80000000/1", i, ibuf_pc, ibuf_instr_valid); end
            end
        end
        drive(1'b1, 64'h8000_0020, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", ibuf_count); end
        checks++; if (fetch_instr_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", fetch_instr_ready); end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd8) begin failures++; $display("FAIL fill_ninth_rejected count got=%0d exp=8", ibuf_count); end
    endtask

    // Drain in order; the first cycle also offers while full with a dequeue.
    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 64'h8000_0040, 1'b1, 1'b0);
            checks++; if (ibuf_instr_valid !== 1'b1 || ibuf_pc !== 64'h8000_0000 + 64'(4 * i)
                          || ibuf_instr !== instr_of(64'h8000_0000 + 64'(4 * i))) begin
                failures++; $display("FAIL drain_head[%0d] got=%b/%h/%h exp pc=%h", i, ibuf_instr_valid, ibuf_pc, ibuf_instr, 64'h8000_0000 + 64'(4 * i));
            end
            if (i == 0) begin
                checks++; if (fetch_instr_ready !== 1'b0) begin failures++; $display("FAIL drain_full_deq_ready got=%b exp=0", fetch_instr_ready); end
            end
            if (i == 1) begin
                checks++; if (ibuf_count !== 4'd7) begin failures++; $display("FAIL drain_full_deq_count got=%0d exp=7", ibuf_count); end
            end
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_instr_valid !== 1'b0 || ibuf_count !== 4'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", ibuf_instr_valid, ibuf_count); end
    endtask

    // Steady push+pop at occupancy 3 across the pointer wrap.
    task automatic test_wrap();
        logic [63:0] base;
        base = 64'h9000_0000;
        for (int k = 0; k < 3; k++) drive(1'b1, base + 64'(4 * k), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, base + 64'(4 * (i + 3)), 1'b1, 1'b0);
            checks++; if (ibuf_count !== 4'd3 || ibuf_pc !== base + 64'(4 * i) || ibuf_instr_valid !== 1'b1) begin
                failures++; $display("FAIL wrap[%0d] got count=%0d pc=%h exp count=3 pc=%h", i, ibuf_count, ibuf_pc, base + 64'(4 * i));
            end
        end
        for (int i = 20; i < 23; i++) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0);
            checks++; if (ibuf_pc !== base + 64'(4 * i)) begin failures++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, ibuf_pc, base + 64'(4 * i)); end
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd0) begin failures++; $display("FAIL wrap_end_count got=%0d exp=0", ibuf_count); end
    endtask

    // Redirect flushes 5 entries and drops the concurrent offer.
    task automatic test_flush();
        for (int k = 0; k < 5; k++) drive(1'b1, 64'hA000_0000 + 64'(4 * k), 1'b0, 1'b0);
        drive(1'b1, 64'h8000_0100, 1'b1, 1'b1);
        checks++; if (ibuf_count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", ibuf_count); end
        checks++; if (fetch_instr_ready !== 1'b0 || ibuf_instr_valid !== 1'b0) begin failures++; $display("FAIL flush_gating got=%b/%b exp=0/0", fetch_instr_ready, ibuf_instr_valid); end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd0 || ibuf_instr_valid !== 1'b0) begin failures++; $display("FAIL flush_post got=%0d/%b exp=0/0", ibuf_count, ibuf_instr_valid); end
        drive(1'b1, 64'h8000_0104, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (ibuf_pc !== 64'h8000_0104 || ibuf_count !== 4'd1) begin failures++; $display("FAIL flush_next_head got=%h/%0d exp=80000104/1", ibuf_pc, ibuf_count); end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset with 4 entries stored.
    task automatic test_reset_midop();
        for (int k = 0; k < 4; k++) drive(1'b1, 64'hB000_0000 + 64'(4 * k), 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd4) begin failures++; $display("FAIL midop_pre_count got=%0d exp=4", ibuf_count); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (ibuf_instr_valid !== 1'b0 || ibuf_count !== 4'd0) begin failures++; $display("FAIL midop_async got=%b/%0d exp=0/0", ibuf_instr_valid, ibuf_count); end
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 64'h8000_0200, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (ibuf_pc !== 64'h8000_0200 || ibuf_count !== 4'd1 || ibuf_instr_valid !== 1'b1) begin
            failures++; $display("FAIL midop_first_head got=%h/%0d exp=80000200/1", ibuf_pc, ibuf_count);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    // Latency of an offer into an empty buffer with decode ready.
    task automatic test_latency();
        drive(1'b1, 64'h8000_0300, 1'b1, 1'b0);
`ifdef IBUFFER_BYPASS_EN
        checks++; if (ibuf_instr_valid !== 1'b1 || ibuf_pc !== 64'h8000_0300) begin failures++; $display("FAIL bypass_same_cycle got=%b/%h exp=1/80000300", ibuf_instr_valid, ibuf_pc); end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (ibuf_count !== 4'd0 || ibuf_instr_valid !== 1'b0) begin failures++; $display("FAIL bypass_not_stored got=%0d/%b exp=0/0", ibuf_count, ibuf_instr_valid); end
`else
        checks++; if (ibuf_instr_valid !== 1'b0 || ibuf_count !== 4'd0) begin failures++; $display("FAIL latency_same_cycle got=%b/%0d exp=0/0", ibuf_instr_valid, ibuf_count); end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (ibuf_instr_valid !== 1'b1 || ibuf_pc !== 64'h8000_0300 || ibuf_count !== 4'd1) begin
            failures++; $display("FAIL latency_next_cycle got=%b/%h/%0d exp=1/80000300/1", ibuf_instr_valid, ibuf_pc, ibuf_count);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        checks++; if (ibuf_count !== 4'd0) begin failures++; $display("FAIL latency_drained got=%0d exp=0", ibuf_count); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_reset_midop();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibuffer.md
IBUFFER -- requirements
Module: ibuffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of 2, min 2).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_instr_valid  input  1  fetch offers an instruction.
REQ-005 SHALL have port fetch_instr  input  32  instruction word from fetch.
REQ-006 SHALL have port fetch_pc  input  64  PC of fetch_instr.
REQ-007 SHALL have port fetch_instr_ready  output  1  buffer accepts this cycle.
REQ-008 SHALL have port ibuf_instr_valid  output  1  head entry valid toward decode.
REQ-009 SHALL have port ibuf_instr  output  32  head instruction word.
REQ-010 SHALL have port ibuf_pc  output  64  head PC.
REQ-011 SHALL have port ibuf_instr_ready  input  1  decode consumes head (backend drives ~mem_stall).
REQ-012 SHALL have port redirect_valid  input  1  backend redirect; flush all entries.
REQ-013 SHALL have port ibuf_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL operate as an in-order FIFO: enqueue on fetch_instr_valid && fetch_instr_ready, dequeue on ibuf_instr_valid && ibuf_instr_ready.
REQ-015 SHALL drive fetch_instr_ready = (count < DEPTH) && !redirect_valid; a full buffer refuses enqueue even if a dequeue occurs the same cycle.
REQ-016 SHALL drive ibuf_instr_valid = (count != 0) && !redirect_valid; ibuf_instr/ibuf_pc read combinationally from the read-pointer entry.
REQ-017 SHALL, on simultaneous enqueue and dequeue (count 1..DEPTH-1), advance both pointers and hold count.
REQ-018 SHALL wrap read and write pointers modulo DEPTH; full/empty from count, not pointer equality.
REQ-019 SHALL give one-cycle latency: an entry enqueued in cycle N is visible at the head no earlier than cycle N+1 (bypass disabled).
REQ-020 SHALL, when redirect_valid is high, reset pointers and count to 0 at the next edge, ignoring any enqueue/dequeue that cycle (flush has priority).
REQ-021 SHALL keep ibuf_count equal to stored entries at all times; never exceed DEPTH, never underflow.
REQ-022 SHALL hold head outputs stable while ibuf_instr_valid && !ibuf_instr_ready.

Reset
REQ-023 SHALL on reset_n low asynchronously clear pointers and count: ibuf_instr_valid 0, ibuf_count 0, fetch_instr_ready 1 (with redirect_valid low).
REQ-024 SHALL not require clearing storage array contents; ibuf_instr/ibuf_pc are don't-care while invalid.
REQ-025 SHALL discard all in-flight entries if reset asserts mid-operation; first post-reset dequeue is the first post-reset enqueue.

Configuration
REQ-026 SHALL, with IBUFFER_BYPASS_EN defined, present fetch inputs directly on ibuf_* when count==0 and fetch_instr_valid (zero latency); if ibuf_instr_ready that cycle, the instruction is consumed and not stored.
REQ-027 SHALL, without IBUFFER_BYPASS_EN, have no combinational path from fetch_* to ibuf_*; REQ-019 latency applies.
REQ-028 SHALL, in both builds, suppress bypass during redirect_valid.

Verification
REQ-029 Fill: ready held 0, enqueue 8 PCs 0x8000_0000..0x8000_001C -> count 8, fetch_instr_ready 0, ninth offer not accepted.
REQ-030 Drain order: after fill, ready 1 for 8 cycles -> ibuf_pc 0x8000_0000..0x8000_001C in order, then valid 0, count 0.
REQ-031 Wrap: continuous enq+deq for 20 cycles at count 3 -> count stays 3, output PC sequence matches input delayed by 3 entries.
REQ-032 Flush: count 5, redirect_valid 1 with fetch offer 0x8000_0100 -> next cycle count 0, valid 0; 0x8000_0100 not stored.
REQ-033 Reset mid-op: count 4, reset_n low 1 cycle asynchronously -> valid 0 immediately, count 0; next enqueue 0x8000_0200 is first head.
REQ-034 Bypass (IBUFFER_BYPASS_EN): empty, offer 0x8000_0300, ready 1 -> ibuf_pc 0x8000_0300 same cycle, count stays 0; without macro -> appears next cycle, count 1 then 0.
